// File: rtl/mipi_csi2_pkt_tx_pkg.sv
// Shared CSI-2 definitions: data types, TX FSM states, and the ECC / CRC-16 helpers
// used by both the packet builder and the byte-level monitor.
package mipi_csi2_pkt_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PLD,
    ST_CRC
  } tx_state_e;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_YUV422_8  = 6'h1E;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_RAW10     = 6'h2B;

  localparam logic [7:0]  LONG_DT_MIN_DEF = 8'h10;
  localparam logic [15:0] CRC_INIT        = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL   = 16'h8408;

  // Modified Hamming code over the 24-bit header word {WC-MSB, WC-LSB, DI}.
  function automatic logic [7:0] mipi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^ d[16]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^ d[17]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^ d[18]
         ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^ d[19]
         ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^ d[18]
         ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return {2'b00, p};
  endfunction

  // Reflected CRC-16 (0x8408), one byte shifted in LSB first.
  function automatic logic [15:0] mipi_crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mipi_csi2_pkt_tx_crc16.sv
// Byte-wide CRC-16 accumulator; init has priority over en.
module mipi_csi2_pkt_tx_crc16
  import mipi_csi2_pkt_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = mipi_crc16_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mipi_csi2_pkt_tx.sv
// CSI-2 packet builder: header request plus payload stream in, serialized
// single-lane byte stream out through one output register.
module mipi_csi2_pkt_tx
  import mipi_csi2_pkt_tx_pkg::*;
#(
  parameter bit         CRC_EN      = 1'b1,
  parameter logic [7:0] LONG_DT_MIN = LONG_DT_MIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [1:0]  hdr_vc,
  input  logic [5:0]  hdr_dt,
  input  logic [15:0] hdr_wc,
  input  logic        pld_valid,
  output logic        pld_ready,
  input  logic [7:0]  pld_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        busy
);

  tx_state_e   state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  ecc_q, ecc_d;
  logic        long_q, long_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;

  logic        adv;
  logic        hdr_fire;
  logic        pld_fire;
  logic [15:0] crc_val;
  logic [15:0] crc_out;

  assign adv       = !out_valid_q || out_ready;
  assign hdr_ready = !rst && (state_q == ST_IDLE) && adv;
  assign pld_ready = !rst && (state_q == ST_PLD) && adv;
  assign hdr_fire  = hdr_valid && hdr_ready;
  assign pld_fire  = pld_valid && pld_ready;
  assign crc_out   = CRC_EN ? crc_val : 16'h0000;

  mipi_csi2_pkt_tx_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (hdr_fire),
    .en   (pld_fire),
    .data (pld_data),
    .crc  (crc_val)
  );

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    rem_d       = rem_q;
    wc_d        = wc_q;
    ecc_d       = ecc_q;
    long_d      = long_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;

    // Every state only produces a byte when the output register can take one.
    if (adv) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (hdr_fire) begin
            wc_d        = hdr_wc;
            ecc_d       = mipi_ecc({hdr_wc, hdr_vc, hdr_dt});
            long_d      = ({2'b00, hdr_dt} >= LONG_DT_MIN);
            out_valid_d = 1'b1;
            out_data_d  = {hdr_vc, hdr_dt};
            out_sop_d   = 1'b1;
            hcnt_d      = 2'd1;
            state_d     = ST_HDR;
          end
        end
        ST_HDR: begin
          out_valid_d = 1'b1;
          case (hcnt_q)
            2'd1: begin
              out_data_d = wc_q[7:0];
              hcnt_d     = 2'd2;
            end
            2'd2: begin
              out_data_d = wc_q[15:8];
              hcnt_d     = 2'd3;
            end
            default: begin
              out_data_d = ecc_q;
              hcnt_d     = 2'd0;
              if (!long_q) begin
                out_eop_d = 1'b1;
                state_d   = ST_IDLE;
              end else if (wc_q == 16'd0) begin
                state_d = ST_CRC;
              end else begin
                rem_d   = wc_q;
                state_d = ST_PLD;
              end
            end
          endcase
        end
        ST_PLD: begin
          if (pld_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = pld_data;
            rem_d       = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = ST_CRC;
            end
          end
        end
        ST_CRC: begin
          out_valid_d = 1'b1;
          if (hcnt_q == 2'd0) begin
            out_data_d = crc_out[7:0];
            hcnt_d     = 2'd1;
          end else begin
            out_data_d = crc_out[15:8];
            out_eop_d  = 1'b1;
            hcnt_d     = 2'd0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hcnt_q      <= '0;
      rem_q       <= '0;
      wc_q        <= '0;
      ecc_q       <= '0;
      long_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      rem_q       <= rem_d;
      wc_q        <= wc_d;
      ecc_q       <= ecc_d;
      long_q      <= long_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign busy      = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_mipi_csi2_pkt_tx.sv
// Directed + randomized bench for mipi_csi2_pkt_tx against a packet-level reference model.
module tb_mipi_csi2_pkt_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid, hdr_ready;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        pld_valid, pld_ready;
  logic [7:0]  pld_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, busy;

  mipi_csi2_pkt_tx dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_vc(hdr_vc), .hdr_dt(hdr_dt), .hdr_wc(hdr_wc),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic       exp_sop[$];
  logic       exp_eop[$];
  logic [7:0] got_q[$];
  logic       got_sop[$];
  logic       got_eop[$];
  logic [7:0] pld_src[$];

  logic       stall_q = 1'b0;
  logic [7:0] stall_data;
  logic       stall_sop, stall_eop;

  // Column code contributed by each header bit to the 6-bit ECC.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  function automatic logic [7:0] m_ecc(input logic [23:0] w);
    logic [5:0] e = 6'h00;
    for (int j = 0; j < 24; j++) if (w[j]) e ^= ECC_COL[j];
    return {2'b00, e};
  endfunction

  // Reflected CRC computed as the plain MSB-first CCITT CRC on bit-reversed bytes.
  function automatic logic [15:0] m_crc(input logic [7:0] d[$]);
    logic [15:0] r = 16'hFFFF;
    logic [15:0] o;
    logic [7:0]  b;
    foreach (d[i]) begin
      for (int j = 0; j < 8; j++) b[j] = d[i][7-j];
      r ^= {b, 8'h00};
      for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    for (int j = 0; j < 16; j++) o[j] = r[15-j];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0]  di;
    logic [15:0] crc;
    int          first;
    first = exp_q.size();
    di = {vc, dt};
    exp_q.push_back(di);
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(m_ecc({wc, di}));
    if (dt >= 6'h10) begin
      foreach (pld_src[i]) exp_q.push_back(pld_src[i]);
      crc = m_crc(pld_src);
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
    for (int i = first; i < exp_q.size(); i++) begin
      exp_sop.push_back(i == first);
      exp_eop.push_back(i == exp_q.size() - 1);
    end
  endtask

  task automatic clear_all();
    exp_q.delete(); exp_sop.delete(); exp_eop.delete();
    got_q.delete(); got_sop.delete(); got_eop.delete();
  endtask

  task automatic fill_pld(input int n);
    pld_src.delete();
    for (int i = 0; i < n; i++) pld_src.push_back(8'($urandom));
  endtask

  task automatic sample_out(input string tag);
    if (stall_q) begin
      chk({tag, " hold_valid"}, out_valid, 1'b1);
      chk({tag, " hold_data"}, out_data, stall_data);
      chk({tag, " hold_sop"}, out_sop, stall_sop);
      chk({tag, " hold_eop"}, out_eop, stall_eop);
    end
    stall_q    = out_valid && !out_ready;
    stall_data = out_data;
    stall_sop  = out_sop;
    stall_eop  = out_eop;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_sop.push_back(out_sop);
      got_eop.push_back(out_eop);
      $display("%s: byte %0d = %02h sop=%0b eop=%0b", tag, got_q.size() - 1, out_data, out_sop, out_eop);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s data%0d", tag, i), got_q[i], exp_q[i]);
        chk($sformatf("%s sop%0d", tag, i), got_sop[i], exp_sop[i]);
        chk($sformatf("%s eop%0d", tag, i), got_eop[i], exp_eop[i]);
      end
    end
  endtask

  // omode: 0 ready always, 1 toggle 1,0,1,0..., 2 random. pmode: 0 payload always valid, 1 random.
  task automatic run_pkt(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc, input int omode, input int pmode);
    bit done = 1'b0;
    bit take_h, take_p;
    int cyc = 0;
    clear_all();
    build_exp(vc, dt, wc);
    hdr_vc = vc; hdr_dt = dt; hdr_wc = wc; hdr_valid = 1'b1;
    while (!done && cyc < 4000) begin
      out_ready = (omode == 0) ? 1'b1 : (omode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      pld_valid = (pld_src.size() != 0) && (pmode == 0 || $urandom_range(0, 2) != 0);
      pld_data  = (pld_src.size() != 0) ? pld_src[0] : 8'h00;
      #1;
      sample_out(tag);
      if (out_valid && out_ready && out_eop) done = 1'b1;
      take_h = hdr_valid && hdr_ready;
      take_p = pld_valid && pld_ready;
      @(posedge clk);
      @(negedge clk);
      if (take_h) hdr_valid = 1'b0;
      if (take_p) void'(pld_src.pop_front());
      cyc++;
    end
    hdr_valid = 1'b0;
    pld_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, " eop_seen"}, done, 1'b1);
    compare(tag);
    #1;
    chk({tag, " idle_valid"}, out_valid, 1'b0);
    chk({tag, " idle_busy"}, busy, 1'b0);
    chk({tag, " idle_pld_ready"}, pld_ready, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int  maxrun, run, stage, npl;
    bit  take_h, take_p, hit;
    logic [5:0] dt;
    logic [15:0] wc;

    rst = 1'b1; hdr_valid = 1'b1; hdr_vc = 2'd1; hdr_dt = 6'h2A; hdr_wc = 16'h0004;
    pld_valid = 1'b0; pld_data = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst hdr_ready", hdr_ready, 1'b0);
    chk("rst pld_ready", pld_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_sop", out_sop, 1'b0);
    chk("rst out_eop", out_eop, 1'b0);
    chk("rst out_data", out_data, 8'h00);
    chk("rst busy", busy, 1'b0);
    hdr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Short frame start: all-zero header, ECC 0
    pld_src.delete();
    run_pkt("short_fs", 2'd0, 6'h00, 16'h0000, 0, 0);
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk($sformatf("short_fs zero%0d", i), got_q[i], 8'h00);

    run_pkt("short_fe", 2'd0, 6'h01, 16'h0000, 0, 0);
    if (got_q.size() > 3) chk("short_fe ecc_const", got_q[3], 8'h07);

    run_pkt("long_empty", 2'd0, 6'h2A, 16'h0000, 2, 0);
    if (got_q.size() == 6) begin
      chk("long_empty crc_lo", got_q[4], 8'hFF);
      chk("long_empty crc_hi", got_q[5], 8'hFF);
    end

    pld_src.delete();
    for (int i = 1; i <= 4; i++) pld_src.push_back(8'(i));
    run_pkt("long4_toggle", 2'd0, 6'h2A, 16'd4, 1, 0);

    // Type boundary on either side of the long/short threshold
    pld_src.delete();
    run_pkt("dt_0f_short", 2'd2, 6'h0F, 16'h00FF, 2, 1);
    fill_pld(1);
    run_pkt("dt_10_long", 2'd1, 6'h10, 16'd1, 2, 1);

    // Back-to-back short packets with hdr_valid held
    clear_all();
    pld_src.delete();
    build_exp(2'd0, 6'h01, 16'h1234);
    build_exp(2'd3, 6'h0A, 16'hBEEF);
    hdr_vc = 2'd0; hdr_dt = 6'h01; hdr_wc = 16'h1234; hdr_valid = 1'b1;
    out_ready = 1'b1; pld_valid = 1'b0;
    stage = 0; run = 0; maxrun = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      sample_out("b2b");
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      take_h = hdr_valid && hdr_ready;
      @(posedge clk);
      @(negedge clk);
      if (take_h) begin
        if (stage == 0) begin
          hdr_vc = 2'd3; hdr_dt = 6'h0A; hdr_wc = 16'hBEEF;
        end else begin
          hdr_valid = 1'b0;
        end
        stage++;
      end
    end
    chk("b2b headers", stage, 2);
    chk("b2b run", maxrun, 8);
    compare("b2b");

    // Randomized packets, random backpressure and payload bubbles
    for (int k = 0; k < 14; k++) begin
      if (k % 3 == 0) begin
        dt = 6'($urandom_range(0, 15));
        wc = 16'($urandom);
        pld_src.delete();
      end else begin
        dt = 6'($urandom_range(16, 63));
        wc = 16'($urandom_range(0, 20));
        fill_pld(int'(wc));
      end
      run_pkt($sformatf("rand%0d", k), 2'($urandom), dt, wc, 2, 1);
    end

    // Reset on the third payload byte of a 16-byte packet
    fill_pld(16);
    hdr_vc = 2'd1; hdr_dt = 6'h2A; hdr_wc = 16'd16; hdr_valid = 1'b1;
    out_ready = 1'b1; npl = 0; hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      pld_valid = (pld_src.size() != 0);
      pld_data  = (pld_src.size() != 0) ? pld_src[0] : 8'h00;
      #1;
      take_h = hdr_valid && hdr_ready;
      take_p = pld_valid && pld_ready;
      if (take_p) npl++;
      @(posedge clk);
      @(negedge clk);
      if (take_h) hdr_valid = 1'b0;
      if (take_p) void'(pld_src.pop_front());
      if (take_p && npl == 3) hit = 1'b1;
    end
    chk("rst_mid reached", hit, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid hdr_ready", hdr_ready, 1'b0);
    chk("rst_mid pld_ready", pld_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_mid out_valid", out_valid, 1'b0);
    chk("rst_mid busy", busy, 1'b0);
    chk("rst_mid out_eop", out_eop, 1'b0);
    rst = 1'b0;
    pld_valid = 1'b0;
    stall_q = 1'b0;
    pld_src.delete();
    @(negedge clk);
    run_pkt("after_rst", 2'd2, 6'h02, 16'h0055, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
